xadc_drp_cobs_packetizer: RTL and testbench
===========================================

Name: xadc_drp_cobs_packetizer

Overview:
- Sequences XADC DRP reads of one voltage and one current-monitor auxiliary channel on every end-of-sequence (EOS) pulse.
- Packs the two 16-bit samples into a 4-byte payload and COBS-encodes it.
- Streams the resulting 6-byte frame, 0x00-delimited, on an 8-bit AXI-Stream source.
- Sits between the XADC primitive (DRP side) and the UART/USB byte-stream path.

Parameters:
- VOLTAGE_DADDR, 7'h14, DRP address of the voltage channel (VAUX4 result register).
- CURRENT_DADDR, 7'h1C, DRP address of the current-monitor channel (VAUX12 result register).

Ports:
- xadc_dclk  input  1  single clock (XADC DCLK); all logic on its rising edge.
- xadc_reset  input  1  asynchronous, active-low reset.
- xadc_daddr  output  7  DRP address.
- xadc_den  output  1  DRP enable, one-cycle pulse per read.
- xadc_drdy  input  1  DRP read data valid.
- xadc_do  input  16  DRP read data.
- xadc_eos  input  1  XADC end-of-sequence pulse.
- packet_tdata  output  8  encoded byte.
- packet_tvalid  output  1  byte valid.
- packet_tready  input  1  downstream ready.
- packet_tlast  output  1  high on the 0x00 delimiter byte.

Behaviour:
- Reset (xadc_reset low, async): state=IDLE; xadc_den=0, xadc_daddr=0, packet_tvalid=0, packet_tdata=0, packet_tlast=0; byte index=0.
- FSM states: IDLE, RD_V, WAIT_V, RD_I, WAIT_I, SEND.
- IDLE: xadc_eos high on a clock edge -> RD_V.
- RD_V: drive xadc_daddr=VOLTAGE_DADDR with xadc_den=1 for exactly one cycle -> WAIT_V.
- WAIT_V: xadc_daddr held; on xadc_drdy=1 capture xadc_do as V -> RD_I.
- RD_I: drive xadc_daddr=CURRENT_DADDR with xadc_den=1 for one cycle -> WAIT_I.
- WAIT_I: on xadc_drdy=1 capture xadc_do as C; build the frame -> SEND.
- No DRP timeout: WAIT states hold until drdy arrives.
- Payload: raw 16-bit DRP words, no shifting or masking, MSB first: P = {V[15:8], V[7:0], C[15:8], C[7:0]}.
- COBS encoding of a 4-byte payload always yields 5 bytes; the frame is those 5 bytes plus a 0x00 delimiter, 6 bytes total, fixed length.
- Each code byte = 1 + number of non-zero bytes up to the next zero or the payload end. Each zero payload byte is replaced by the next code byte.
- The frame is computed combinationally from P and registered into a 6-byte buffer on entry to SEND.
- SEND: packet_tvalid=1; packet_tdata = buffer[index]; packet_tlast=1 only at index 5.
- SEND advance: only on tvalid&&tready. After the index-5 transfer, return to IDLE with tvalid=0 in the next cycle.
- AXIS rule: while tvalid=1 and tready=0, tdata/tlast hold stable.
- Latency: first byte valid no earlier than 2 cycles after the second drdy; back-to-back bytes at 1/cycle when tready=1.
- EOS arriving in any non-IDLE state is ignored (sample set dropped); no queuing.
- xadc_drdy arriving in IDLE, RD_V, RD_I or SEND is ignored.
- Reset mid-packet aborts the frame immediately; no partial-frame resumption.

Optional Feature:
- Macro: XADC_PKT_DROP_CNT_EN.
- When defined: adds output port dropped_count[15:0]. It resets to 0 and increments (saturating at 16'hFFFF) on every clock edge where xadc_eos=1 while state != IDLE.
- When not defined: no port, no counter; EOS outside IDLE is silently ignored.

Test Plan:
- tready=1; BFM returns V=0x00FF, C=0x007F -> bytes 01 02 FF 02 7F 00; tlast only on the 00.
- V=0x1234, C=0x5678 -> 05 12 34 56 78 00.
- V=0x0000, C=0x0000 -> 01 01 01 01 01 00. V=0xAB00, C=0x00CD -> 02 AB 01 02 CD 00.
- tready toggled pseudo-randomly -> same 6 bytes in order; tdata/tlast stable while stalled; den pulses exactly twice per EOS, with addresses 0x14 then 0x1C.
- Second EOS during SEND -> ignored, only one frame output; with XADC_PKT_DROP_CNT_EN, dropped_count=1.
- Reset asserted at byte 3 -> tvalid low asynchronously; the next EOS produces a complete fresh 6-byte frame.

Source files
------------

// File: rtl/xadc_drp_cobs_packetizer.sv
// Reads one voltage and one current aux channel over DRP on each XADC EOS and streams
// the pair as a 6-byte COBS frame with 0x00 delimiter. Optional macro: XADC_PKT_DROP_CNT_EN.
module xadc_drp_cobs_packetizer #(
    parameter logic [6:0] VOLTAGE_DADDR = 7'h14,
    parameter logic [6:0] CURRENT_DADDR = 7'h1C
) (
    input  logic        xadc_dclk,
    input  logic        xadc_reset,
    output logic [6:0]  xadc_daddr,
    output logic        xadc_den,
    input  logic        xadc_drdy,
    input  logic [15:0] xadc_do,
    input  logic        xadc_eos,
    output logic [7:0]  packet_tdata,
    output logic        packet_tvalid,
    input  logic        packet_tready,
    output logic        packet_tlast
`ifdef XADC_PKT_DROP_CNT_EN
    ,
    output logic [15:0] dropped_count
`endif
);

    typedef enum logic [2:0] {IDLE, RD_V, WAIT_V, RD_I, WAIT_I, SEND} state_t;

    state_t      r_state, w_next;
    logic [15:0] r_v, r_c;
    logic [7:0]  r_buf [6];
    logic [2:0]  r_idx;
    logic        r_tvalid;
    logic [7:0]  w_pay [4];
    logic [7:0]  w_enc [5];
    logic [7:0]  w_run;
    logic        w_xfer;

    assign w_xfer = r_tvalid && packet_tready;

    always_comb begin
        w_next     = r_state;
        xadc_den   = 1'b0;
        xadc_daddr = 7'h00;
        case (r_state)
            IDLE:   if (xadc_eos) w_next = RD_V;
            RD_V:   begin xadc_den = 1'b1; xadc_daddr = VOLTAGE_DADDR; w_next = WAIT_V; end
            WAIT_V: begin xadc_daddr = VOLTAGE_DADDR; if (xadc_drdy) w_next = RD_I; end
            RD_I:   begin xadc_den = 1'b1; xadc_daddr = CURRENT_DADDR; w_next = WAIT_I; end
            WAIT_I: begin xadc_daddr = CURRENT_DADDR; if (xadc_drdy) w_next = SEND; end
            SEND:   if (w_xfer && r_idx == 3'd5) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // COBS encode walking backwards: each zero takes the run length of what follows it.
    always_comb begin
        w_pay[0] = r_v[15:8];
        w_pay[1] = r_v[7:0];
        w_pay[2] = r_c[15:8];
        w_pay[3] = r_c[7:0];
        w_run    = 8'd1;
        for (int i = 0; i < 5; i++) w_enc[i] = 8'h00;
        for (int i = 3; i >= 0; i--) begin
            if (w_pay[i] == 8'h00) begin
                w_enc[i+1] = w_run;
                w_run      = 8'd1;
            end else begin
                w_enc[i+1] = w_pay[i];
                w_run      = w_run + 8'd1;
            end
        end
        w_enc[0] = w_run;
    end

    always_ff @(posedge xadc_dclk or negedge xadc_reset) begin
        if (!xadc_reset) begin
            r_state  <= IDLE;
            r_v      <= '0;
            r_c      <= '0;
            r_idx    <= '0;
            r_tvalid <= 1'b0;
            for (int i = 0; i < 6; i++) r_buf[i] <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == WAIT_V && xadc_drdy) r_v <= xadc_do;
            if (r_state == WAIT_I && xadc_drdy) r_c <= xadc_do;
            // First SEND cycle latches the encoded frame; tvalid rises one cycle later.
            if (r_state == SEND) begin
                if (!r_tvalid) begin
                    for (int i = 0; i < 5; i++) r_buf[i] <= w_enc[i];
                    r_buf[5] <= 8'h00;
                    r_idx    <= 3'd0;
                    r_tvalid <= 1'b1;
                end else if (packet_tready) begin
                    if (r_idx == 3'd5) begin
                        r_tvalid <= 1'b0;
                        r_idx    <= 3'd0;
                    end else begin
                        r_idx <= r_idx + 3'd1;
                    end
                end
            end
        end
    end

    always_comb begin
        packet_tdata = 8'h00;
        if (r_tvalid) begin
            case (r_idx)
                3'd0: packet_tdata = r_buf[0];
                3'd1: packet_tdata = r_buf[1];
                3'd2: packet_tdata = r_buf[2];
                3'd3: packet_tdata = r_buf[3];
                3'd4: packet_tdata = r_buf[4];
                3'd5: packet_tdata = r_buf[5];
                default: packet_tdata = 8'h00;
            endcase
        end
    end

    assign packet_tvalid = r_tvalid;
    assign packet_tlast  = r_tvalid && (r_idx == 3'd5);

`ifdef XADC_PKT_DROP_CNT_EN
    logic [15:0] r_drop;
    always_ff @(posedge xadc_dclk or negedge xadc_reset) begin
        if (!xadc_reset)
            r_drop <= '0;
        else if (xadc_eos && r_state != IDLE && r_drop != 16'hFFFF)
            r_drop <= r_drop + 16'd1;
    end
    assign dropped_count = r_drop;
`endif

endmodule

// File: tb/tb_xadc_drp_cobs_packetizer.sv
// Directed + randomized bench: DRP responder, queue-based COBS reference model, AXIS sink.
module tb_xadc_drp_cobs_packetizer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  xadc_daddr;
    logic        xadc_den;
    logic        xadc_drdy;
    logic [15:0] xadc_do;
    logic        xadc_eos;
    logic [7:0]  packet_tdata;
    logic        packet_tvalid;
    logic        packet_tready;
    logic        packet_tlast;
`ifdef XADC_PKT_DROP_CNT_EN
    logic [15:0] dropped_count;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [15:0] tv_v, tv_c;
    logic [6:0]  den_addrs[$];
    logic [7:0]  exp_frame [6];

    always #5 clk = ~clk;

    xadc_drp_cobs_packetizer dut (
        .xadc_dclk     (clk),
        .xadc_reset    (rst_n),
        .xadc_daddr    (xadc_daddr),
        .xadc_den      (xadc_den),
        .xadc_drdy     (xadc_drdy),
        .xadc_do       (xadc_do),
        .xadc_eos      (xadc_eos),
        .packet_tdata  (packet_tdata),
        .packet_tvalid (packet_tvalid),
        .packet_tready (packet_tready),
        .packet_tlast  (packet_tlast)
`ifdef XADC_PKT_DROP_CNT_EN
        ,
        .dropped_count (dropped_count)
`endif
    );

    // DRP responder: answers each den after 1..4 cycles with the word for that address
    initial begin
        logic [6:0] a;
        xadc_drdy = 1'b0;
        xadc_do   = 16'h0;
        forever begin
            @(negedge clk);
            if (xadc_den === 1'b1) begin
                a = xadc_daddr;
                den_addrs.push_back(a);
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #1;
                xadc_drdy = 1'b1;
                xadc_do   = (a == 7'h14) ? tv_v : tv_c;
                @(posedge clk);
                #1;
                xadc_drdy = 1'b0;
                xadc_do   = 16'($urandom);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference COBS: forward pass, reserving a code byte slot per segment and back-filling it.
    task automatic build_expected(input logic [15:0] v, input logic [15:0] c);
        logic [7:0] p [4];
        logic [7:0] q[$];
        int ci, code;
        p[0] = v[15:8]; p[1] = v[7:0]; p[2] = c[15:8]; p[3] = c[7:0];
        q.push_back(8'h00);
        ci = 0;
        code = 1;
        for (int k = 0; k < 4; k++) begin
            if (p[k] == 8'h00) begin
                q[ci] = 8'(code);
                ci = q.size();
                q.push_back(8'h00);
                code = 1;
            end else begin
                q.push_back(p[k]);
                code++;
            end
        end
        q[ci] = 8'(code);
        q.push_back(8'h00);
        for (int k = 0; k < 6; k++) exp_frame[k] = q[k];
    endtask

    task automatic pulse_eos();
        xadc_eos = 1'b1;
        tick();
        xadc_eos = 1'b0;
    endtask

    task automatic run_frame(input logic [15:0] v, input logic [15:0] c,
                             input bit rnd_ready, input bit extra_eos);
        int got = 0, cyc = 0;
        bit stalled = 0, eos_sent = 0;
        logic [7:0] pd;
        logic pl;
        tv_v = v;
        tv_c = c;
        den_addrs.delete();
        build_expected(v, c);
        pulse_eos();
        while (got < 6 && cyc < 400) begin
            packet_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (extra_eos && !eos_sent && packet_tvalid) begin
                xadc_eos = 1'b1;
                eos_sent = 1;
            end
            @(negedge clk);
            if (stalled) begin
                chk("hold_valid", packet_tvalid, 1);
                chk("hold_data", packet_tdata, pd);
                chk("hold_last", packet_tlast, pl);
            end
            if (packet_tvalid && packet_tready) begin
                chk($sformatf("byte%0d", got), packet_tdata, exp_frame[got]);
                chk($sformatf("last%0d", got), packet_tlast, (got == 5));
                got++;
            end
            stalled = packet_tvalid && !packet_tready;
            pd = packet_tdata;
            pl = packet_tlast;
            tick();
            xadc_eos = 1'b0;
            cyc++;
        end
        chk("frame_timeout_bytes", got, 6);
        packet_tready = 1'b1;
        repeat (20) tick();
        chk("idle_after_frame", packet_tvalid, 0);
        chk("den_count", den_addrs.size(), 2);
        chk("den_addr0", den_addrs.size() > 0 ? den_addrs[0] : 7'h7F, 7'h14);
        chk("den_addr1", den_addrs.size() > 1 ? den_addrs[1] : 7'h7F, 7'h1C);
    endtask

    initial begin
        logic [15:0] v, c;
        int got, cyc;
        rst_n         = 1'b0;
        xadc_eos      = 1'b0;
        packet_tready = 1'b1;
        tv_v          = 16'h0;
        tv_c          = 16'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tvalid", packet_tvalid, 0);
        chk("rst_tdata", packet_tdata, 0);
        chk("rst_tlast", packet_tlast, 0);
        chk("rst_den", xadc_den, 0);
        chk("rst_daddr", xadc_daddr, 0);
`ifdef XADC_PKT_DROP_CNT_EN
        chk("rst_drop", dropped_count, 0);
`endif
        rst_n = 1'b1;
        tick();

        run_frame(16'h00FF, 16'h007F, 0, 0);
        run_frame(16'h1234, 16'h5678, 0, 0);
        run_frame(16'h0000, 16'h0000, 0, 0);
        run_frame(16'hAB00, 16'h00CD, 0, 0);
        run_frame(16'h1234, 16'h5678, 1, 0);
        run_frame(16'h00FF, 16'h0001, 0, 1);
`ifdef XADC_PKT_DROP_CNT_EN
        chk("drop_cnt", dropped_count, 1);
`endif
        for (int n = 0; n < 8; n++) begin
            v = 16'($urandom);
            c = 16'($urandom);
            if ($urandom_range(0, 1)) v[15:8] = 8'h00;
            if ($urandom_range(0, 1)) v[7:0]  = 8'h00;
            if ($urandom_range(0, 1)) c[15:8] = 8'h00;
            if ($urandom_range(0, 1)) c[7:0]  = 8'h00;
            run_frame(v, c, 1, 0);
        end

        // Abort while byte 3 is on the bus
        tv_v = 16'h1111;
        tv_c = 16'h2222;
        build_expected(tv_v, tv_c);
        pulse_eos();
        got = 0;
        cyc = 0;
        packet_tready = 1'b1;
        while (cyc < 400) begin
            @(negedge clk);
            if (packet_tvalid && got == 3) break;
            if (packet_tvalid) got++;
            tick();
            cyc++;
        end
        chk("abort_reached_b3", got, 3);
        chk("abort_b3_data", packet_tdata, exp_frame[3]);
        rst_n = 1'b0;
        #1;
        chk("abort_tvalid", packet_tvalid, 0);
        chk("abort_tlast", packet_tlast, 0);
        chk("abort_tdata", packet_tdata, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run_frame(16'hBEEF, 16'h0F00, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
